branch_unit: RTL and testbench
==============================

// Module: branch_unit
// PURPOSE
//  Downstream consumer of the lt/eq/gt comparator flags. Holds a 3-bit flag register
//  updated on ALU flag-writes, accepts one branch request at a time over a valid/ready
//  handshake, resolves the condition, and drives a one-cycle PC-load pulse plus a
//  fetch/decode flush window to the front end of the processor.
// PARAMETERS
//  PC_W       32  width of pc, offset, pc_next
//  FLUSH_CYC  2   cycles flush stays high after a taken branch (>=1)
// PORTS
//  clk       in   1     system clock, rising edge
//  rst       in   1     asynchronous, active-high reset
//  flag_we   in   1     latch {lt,eq,gt} into flag register this edge
//  lt        in   1     comparator less-than (result negative)
//  eq        in   1     comparator equal (result zero)
//  gt        in   1     comparator greater-than (result positive, non-zero)
//  br_valid  in   1     branch request valid
//  br_ready  out  1     unit can accept a request (high only in IDLE)
//  br_op     in   3     condition: 0 BR always, 1 BMI lt, 2 BPL gt|eq, 3 BZ eq,
//                       4 BNZ ~eq, 5 BGT gt, 6 BLE lt|eq, 7 NOP never taken
//  pc        in   PC_W  address of the branch instruction
//  offset    in   PC_W  byte offset, already sign-extended, two's complement
//  pc_load   out  1     one-cycle pulse: fetch must load pc_next
//  pc_next   out  PC_W  resolved next PC, valid while pc_load=1
//  taken     out  1     qualifies pc_load: 1 taken, 0 fall-through
//  flush     out  1     kill younger in-flight instructions
//  flags_q   out  3     flag register {lt,eq,gt}
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, br_ready=1, pc_load=0, taken=0, flush=0,
//    pc_next=0, flags_q=3'b010, flush counter=0; captured request discarded.
//  - Flag register: on edge with flag_we=1, flags_q<={lt,eq,gt}; independent of FSM.
//  - FSM states IDLE, RESOLVE, FLUSH.
//    IDLE:    br_ready=1; br_valid&br_ready at edge -> capture br_op/pc/offset, ->RESOLVE.
//    RESOLVE: br_ready=0; evaluate cond on f_eff = flag_we ? {lt,eq,gt} : flags_q
//             (same-cycle forwarding). At edge: pc_load<=1, taken<=cond,
//             pc_next<= cond ? pc+offset : pc+4; cond ? ->FLUSH : ->IDLE.
//    FLUSH:   br_ready=0; flush=1 for exactly FLUSH_CYC cycles starting the cycle
//             pc_load is high; then ->IDLE.
//  - pc_load is high exactly one cycle per accepted request; taken/pc_next hold last
//    value otherwise (only meaningful with pc_load).
//  - Latency: accept edge k -> pc_load high in cycle after edge k+1 (2 edges).
//    Back-to-back throughput: 1 request per 2 cycles not-taken, 2+FLUSH_CYC taken.
//  - Arithmetic: pc+offset and pc+4 are PC_W-bit, wrap modulo 2^PC_W, no overflow flag.
//  - Non-one-hot flags (e.g. 000, 110) are used as-is bitwise; no error raised.
//  - br_valid while br_ready=0 is ignored; requester must hold until accepted.
//  - Flag writes during RESOLVE affect that resolution (forwarding); writes during
//    FLUSH only update flags_q.
// TESTING
//  1 Reset: assert rst mid-FLUSH -> immediately flush=0,pc_load=0,br_ready=1,flags_q=010.
//  2 flag_we lt=1; BMI pc=0x100 off=0x20 -> pc_load 1 cycle, taken=1, pc_next=0x120,
//    flush high 2 cycles, br_ready back high after.
//  3 flags_q eq=1; BNZ pc=0x200 -> taken=0, pc_next=0x204, flush never asserted,
//    next request accepted the cycle after pc_load.
//  4 Forwarding: flags_q=010, flag_we with gt=1 in RESOLVE of BGT -> taken=1.
//  5 Wrap: BR pc=0xFFFFFFF8 off=0x10 -> pc_next=0x8; BR pc=0x10 off=0xFFFFFFF0 -> 0x0.
//  6 br_valid held high continuously with 4 mixed ops -> exactly 4 pc_load pulses,
//    none during FLUSH, ops resolved in order; NOP -> taken=0, pc_next=pc+4.

Source files
------------

// File: rtl/branch_unit_if.sv
// Branch request handshake from decode plus the redirect/flush outputs toward fetch.
interface branch_unit_if #(
  parameter int PC_W = 32
);
  logic            br_valid;
  logic            br_ready;
  logic [2:0]      br_op;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] offset;
  logic            pc_load;
  logic [PC_W-1:0] pc_next;
  logic            taken;
  logic            flush;

  modport master (
    output br_valid, br_op, pc, offset,
    input  br_ready, pc_load, pc_next, taken, flush
  );

  modport slave (
    input  br_valid, br_op, pc, offset,
    output br_ready, pc_load, pc_next, taken, flush
  );
endinterface

// File: rtl/branch_unit.sv
// Branch resolution unit: holds the lt/eq/gt flag register, resolves one branch at a
// time and drives a one-cycle PC-load pulse followed by a front-end flush window.
module branch_unit #(
  parameter int PC_W      = 32,
  parameter int FLUSH_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flag_we_i,
  input  logic               lt_i,
  input  logic               eq_i,
  input  logic               gt_i,
  branch_unit_if.slave       br_if,
  output logic [2:0]         flags_o
);

  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RESOLVE,
    FLUSH
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q;
  logic [PC_W-1:0] pc_q, off_q;
  logic            capture;
  logic            pc_load_q, pc_load_d;
  logic            taken_q, taken_d;
  logic [PC_W-1:0] pc_next_q, pc_next_d;
  logic [2:0]      flags_q, flags_d;
  logic [2:0]      f_eff;
  logic            cond;

  // A flag write in the resolve cycle is forwarded so the branch sees the newest result.
  always_comb begin
    f_eff = flag_we_i ? {lt_i, eq_i, gt_i} : flags_q;
    cond  = 1'b0;
    case (op_q)
      3'd0: cond = 1'b1;
      3'd1: cond = f_eff[2];
      3'd2: cond = f_eff[0] | f_eff[1];
      3'd3: cond = f_eff[1];
      3'd4: cond = ~f_eff[1];
      3'd5: cond = f_eff[0];
      3'd6: cond = f_eff[2] | f_eff[1];
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    pc_load_d = 1'b0;
    taken_d   = taken_q;
    pc_next_d = pc_next_q;
    flags_d   = flag_we_i ? {lt_i, eq_i, gt_i} : flags_q;
    case (state_q)
      IDLE: begin
        if (br_if.br_valid) begin
          capture = 1'b1;
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        pc_load_d = 1'b1;
        taken_d   = cond;
        pc_next_d = cond ? (pc_q + off_q) : (pc_q + PC_W'(4));
        cnt_d     = '0;
        state_d   = cond ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 3'd7;
      pc_q      <= '0;
      off_q     <= '0;
      pc_load_q <= 1'b0;
      taken_q   <= 1'b0;
      pc_next_q <= '0;
      flags_q   <= 3'b010;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_load_q <= pc_load_d;
      taken_q   <= taken_d;
      pc_next_q <= pc_next_d;
      flags_q   <= flags_d;
      if (capture) begin
        op_q  <= br_if.br_op;
        pc_q  <= br_if.pc;
        off_q <= br_if.offset;
      end
    end
  end

  assign br_if.br_ready = (state_q == IDLE);
  assign br_if.flush    = (state_q == FLUSH);
  assign br_if.pc_load  = pc_load_q;
  assign br_if.taken    = taken_q;
  assign br_if.pc_next  = pc_next_q;
  assign flags_o        = flags_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios plus random branches
// checked against a flag/branch reference model.
module tb_branch_unit;

  localparam int FLUSH_CYC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       flag_we, lt, eq, gt;
  logic [2:0] flags_o;

  int compared   = 0;
  int mismatched = 0;
  logic [2:0] modelFlags;

  branch_unit_if #(.PC_W(32)) bif ();

  branch_unit #(.PC_W(32), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .flag_we_i (flag_we),
    .lt_i      (lt),
    .eq_i      (eq),
    .gt_i      (gt),
    .br_if     (bif),
    .flags_o   (flags_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Branch condition from the ISA table, flags given as {lt,eq,gt}.
  function automatic logic condOf(input logic [2:0] op, input logic [2:0] f);
    logic l, e, g;
    {l, e, g} = f;
    case (op)
      3'd0: return 1'b1;
      3'd1: return l;
      3'd2: return g || e;
      3'd3: return e;
      3'd4: return !e;
      3'd5: return g;
      3'd6: return l || e;
      default: return 1'b0;
    endcase
  endfunction

  task automatic writeFlags(input logic [2:0] bits);
    @(negedge clk);
    flag_we = 1'b1;
    {lt, eq, gt} = bits;
    @(negedge clk);
    flag_we = 1'b0;
    modelFlags = bits;
    checkOutput("flags_write", {29'd0, flags_o}, {29'd0, modelFlags});
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] pcV, input logic [31:0] offV,
                               input bit fwd, input logic [2:0] fwdFlags);
    logic [2:0]  fEff;
    logic        expTaken;
    logic [31:0] expNext;
    @(negedge clk);
    checkOutput("ready_idle", {31'd0, bif.br_ready}, 32'd1);
    bif.br_valid = 1'b1;
    bif.br_op    = op;
    bif.pc       = pcV;
    bif.offset   = offV;
    @(negedge clk);
    bif.br_valid = 1'b0;
    checkOutput("ready_resolve", {31'd0, bif.br_ready}, 32'd0);
    checkOutput("pcload_resolve", {31'd0, bif.pc_load}, 32'd0);
    fEff = modelFlags;
    if (fwd) begin
      flag_we = 1'b1;
      {lt, eq, gt} = fwdFlags;
      fEff = fwdFlags;
      modelFlags = fwdFlags;
    end
    expTaken = condOf(op, fEff);
    expNext  = expTaken ? pcV + offV : pcV + 32'd4;
    @(negedge clk);
    flag_we = 1'b0;
    checkOutput("pc_load", {31'd0, bif.pc_load}, 32'd1);
    checkOutput("taken", {31'd0, bif.taken}, {31'd0, expTaken});
    checkOutput("pc_next", bif.pc_next, expNext);
    checkOutput("flush_first", {31'd0, bif.flush}, {31'd0, expTaken});
    checkOutput("ready_load", {31'd0, bif.br_ready}, {31'd0, !expTaken});
    checkOutput("flags_q", {29'd0, flags_o}, {29'd0, modelFlags});
    if (expTaken) begin
      for (int i = 1; i < FLUSH_CYC; i++) begin
        @(negedge clk);
        checkOutput("flush_hold", {31'd0, bif.flush}, 32'd1);
        checkOutput("pcload_flush", {31'd0, bif.pc_load}, 32'd0);
        checkOutput("ready_flush", {31'd0, bif.br_ready}, 32'd0);
      end
      @(negedge clk);
      checkOutput("flush_end", {31'd0, bif.flush}, 32'd0);
      checkOutput("ready_after", {31'd0, bif.br_ready}, 32'd1);
    end
  endtask

  logic [2:0]  sOp  [4];
  logic [31:0] sPc  [4];
  logic [31:0] sOff [4];
  logic        sExpTaken [4];
  logic [31:0] sExpNext  [4];

  initial begin
    int idx, pulses, cycles, extra;
    rst = 1'b1;
    flag_we = 1'b0;
    {lt, eq, gt} = 3'b000;
    bif.br_valid = 1'b0;
    bif.br_op = 3'd0;
    bif.pc = '0;
    bif.offset = '0;
    modelFlags = 3'b010;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'd0, bif.br_ready}, 32'd1);
    checkOutput("rst_pcload", {31'd0, bif.pc_load}, 32'd0);
    checkOutput("rst_taken", {31'd0, bif.taken}, 32'd0);
    checkOutput("rst_flush", {31'd0, bif.flush}, 32'd0);
    checkOutput("rst_pcnext", bif.pc_next, 32'd0);
    checkOutput("rst_flags", {29'd0, flags_o}, 32'd2);
    rst = 1'b0;

    $display("[TB] taken BMI");
    writeFlags(3'b100);
    applyStimulus(3'd1, 32'h100, 32'h20, 1'b0, 3'b000);

    $display("[TB] not-taken BNZ then immediate follow-up");
    writeFlags(3'b010);
    applyStimulus(3'd4, 32'h200, 32'h40, 1'b0, 3'b000);
    applyStimulus(3'd3, 32'h208, 32'h10, 1'b0, 3'b000);

    $display("[TB] forwarding into BGT");
    writeFlags(3'b010);
    applyStimulus(3'd5, 32'h300, 32'h8, 1'b1, 3'b001);

    $display("[TB] wrap-around");
    applyStimulus(3'd0, 32'hFFFF_FFF8, 32'h10, 1'b0, 3'b000);
    applyStimulus(3'd0, 32'h10, 32'hFFFF_FFF0, 1'b0, 3'b000);

    $display("[TB] random branches");
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) writeFlags(3'($urandom_range(0, 7)));
      applyStimulus(3'($urandom_range(0, 7)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    $display("[TB] streaming requests with br_valid held");
    writeFlags(3'b100);
    sOp  = '{3'd0, 3'd3, 3'd7, 3'd1};
    sPc  = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
    sOff = '{32'h40, 32'h80, 32'h100, 32'hFFFF_FF00};
    for (int i = 0; i < 4; i++) begin
      sExpTaken[i] = condOf(sOp[i], modelFlags);
      sExpNext[i]  = sExpTaken[i] ? sPc[i] + sOff[i] : sPc[i] + 32'd4;
    end
    @(negedge clk);
    bif.br_valid = 1'b1;
    bif.br_op = sOp[0];
    bif.pc = sPc[0];
    bif.offset = sOff[0];
    idx = 1;
    pulses = 0;
    cycles = 0;
    while (pulses < 4 && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (bif.pc_load === 1'b1) begin
        checkOutput("stream_taken", {31'd0, bif.taken}, {31'd0, sExpTaken[pulses]});
        checkOutput("stream_next", bif.pc_next, sExpNext[pulses]);
        pulses++;
      end
      if (bif.br_ready === 1'b1) begin
        if (idx < 4) begin
          bif.br_op = sOp[idx];
          bif.pc = sPc[idx];
          bif.offset = sOff[idx];
          idx++;
        end else begin
          bif.br_valid = 1'b0;
        end
      end
    end
    bif.br_valid = 1'b0;
    checkOutput("stream_pulses", pulses, 32'd4);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bif.pc_load !== 1'b0) extra++;
    end
    checkOutput("stream_extra", extra, 32'd0);

    $display("[TB] reset during flush");
    writeFlags(3'b101);
    @(negedge clk);
    bif.br_valid = 1'b1;
    bif.br_op = 3'd0;
    bif.pc = 32'h40;
    bif.offset = 32'h10;
    @(negedge clk);
    bif.br_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_flush", {31'd0, bif.flush}, 32'd1);
    checkOutput("pre_rst_pcload", {31'd0, bif.pc_load}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_flush", {31'd0, bif.flush}, 32'd0);
    checkOutput("async_rst_pcload", {31'd0, bif.pc_load}, 32'd0);
    checkOutput("async_rst_ready", {31'd0, bif.br_ready}, 32'd1);
    checkOutput("async_rst_flags", {29'd0, flags_o}, 32'd2);
    checkOutput("async_rst_pcnext", bif.pc_next, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    modelFlags = 3'b010;
    applyStimulus(3'd3, 32'h500, 32'h20, 1'b0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
